temp_sensor_filter: RTL
=======================

TEMP_SENSOR_FILTER -- requirements
Module: temp_sensor_filter

Interface
REQ-001 Parameter SAMPLE_PERIOD, default 1000, SHALL set the clk cycles from the end of one conversion to the start of the next.
REQ-002 Parameter SCLK_HALF, default 4, SHALL set the clk cycles per sensor_sclk half-period.
REQ-003 clk  input  1  SHALL be the single clock; all logic updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 sensor_sdo  input  1  SHALL carry serial data from the sensor: 8-bit two's-complement whole degrees C, MSB first.
REQ-006 sensor_cs_n  output  1  SHALL be the sensor chip select, active low.
REQ-007 sensor_sclk  output  1  SHALL be the sensor serial clock, idle low.
REQ-008 temperature  output  5  SHALL be the filtered temperature fed to the AC controller, registered.
REQ-009 temp_valid  output  1  SHALL pulse high for one cycle whenever temperature is updated.

Function
REQ-010 FSM states SHALL be IDLE, SETUP, SHIFT and UPDATE.
REQ-011 In IDLE a period counter SHALL count to SAMPLE_PERIOD-1, then move to SETUP; the first conversion after reset SHALL start on the cycle after rst_n deasserts.
REQ-012 SETUP SHALL drive sensor_cs_n low with sensor_sclk low for SCLK_HALF cycles, then move to SHIFT.
REQ-013 SHIFT SHALL generate 8 sclk periods of 2*SCLK_HALF cycles each, low phase first.
REQ-014 sensor_sdo SHALL be sampled on the clk edge where sensor_sclk goes high and shifted in MSB first.
REQ-015 After the 8th low phase completes, SHIFT SHALL move to UPDATE, with sensor_cs_n high and sensor_sclk low from that cycle.
REQ-016 UPDATE SHALL last one cycle, clamp the raw byte, write the window, and return to IDLE with the period counter cleared.
REQ-017 Clamp rule: a negative raw value SHALL map to 0, a value above 31 SHALL map to 31, and any other value SHALL pass unchanged.
REQ-018 The window SHALL hold the last 4 clamped samples, with the newest sample replacing the oldest.
REQ-019 The first sample after reset SHALL be written to all 4 window entries.
REQ-020 temperature SHALL equal the 7-bit sum of the 4 entries shifted right by 2 (truncating).
REQ-021 temperature SHALL update, and temp_valid SHALL pulse, on the cycle after UPDATE.
REQ-022 temperature SHALL hold its value between updates.
REQ-023 End-to-end latency from sensor_cs_n falling to temp_valid SHALL be SCLK_HALF*17+2 cycles.
REQ-024 sensor_sdo values outside the sample edges SHALL have no effect on any output.

Reset
REQ-025 Asserting rst_n low at any time, including mid-SHIFT, SHALL abort the conversion immediately without updating the window.
REQ-026 Reset values SHALL be: state IDLE, sensor_cs_n 1, sensor_sclk 0, temp_valid 0, window empty and marked unfilled, counters 0.
REQ-027 The reset value of temperature SHALL be 20, which keeps the AC controller idle.

Structure
REQ-028 Package temp_pkg SHALL hold the FSM state enum and the constants T_MIN=0, T_MAX=31 and T_RESET=20.
REQ-029 The serial engine (SETUP/SHIFT timing, shift register, bit counter) SHALL be a sub-module named sensor_spi_rx with start/done/data handshake.
REQ-030 Filtering and clamping SHALL stay in the top module.

Verification (SCLK_HALF=2, SAMPLE_PERIOD=20)
REQ-031 Reset release, sensor returns 0x17 (23) -> one temp_valid pulse, temperature=23, latency 36 cycles from cs_n falling.
REQ-032 After a fill with 20, samples 20,20,20,24 -> temperature sequence 20,20,20,21.
REQ-033 Raw 0xF6 (-10) -> clamped 0; raw 0x40 (64) -> clamped 31; after first-sample fill, temperature is 0 and 31 respectively.
REQ-034 rst_n pulsed low during the 5th sclk period -> cs_n high and temperature=20 immediately, no temp_valid, and the next sample fills all entries.
REQ-035 Steady 18 for 4 samples, then 22 for 4 samples -> temperature sequence 18,19,20,21,22, verifying that the AC threshold crossings happen only via the average.
REQ-036 The bench SHALL check that cs_n stays high for exactly SAMPLE_PERIOD+1 cycles between conversions and that sclk toggles exactly 16 times per conversion.

Source files
------------

// File: rtl/temp_pkg.sv
// Shared types and constants for the temperature sensor front end.
// Holds the FSM state encoding, clamp limits and the clamp helper.
package temp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        SHIFT  = 2'd2,
        UPDATE = 2'd3
    } state_t;

    typedef logic [4:0] temp_t;

    localparam temp_t T_MIN   = 5'd0;
    localparam temp_t T_MAX   = 5'd31;
    localparam temp_t T_RESET = 5'd20;

    localparam int N_BITS = 8;

    // Raw byte is two's complement: sign bit forces floor, bits 6:5 set means above T_MAX.
    function automatic temp_t clamp_temp(input logic [N_BITS-1:0] raw);
        temp_t t;
        if (raw[7]) begin
            t = T_MIN;
        end else if (raw[6:5] != 2'b00) begin
            t = T_MAX;
        end else begin
            t = raw[4:0];
        end
        return t;
    endfunction

endpackage

// File: rtl/sensor_spi_rx.sv
// Serial receive engine: chip-select setup, 8 sclk periods, MSB-first capture.
// Conversion takes SCLK_HALF*17 cycles from start; start is ignored while busy.
module sensor_spi_rx
    import temp_pkg::*;
#(
    parameter int SCLK_HALF = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              sdo_i,
    output logic              cs_n_o,
    output logic              sclk_o,
    output logic              setup_done_o,
    output logic              done_o,
    output logic [N_BITS-1:0] data_o
);

    localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);

    state_t              ph_q, ph_d;
    logic [HW-1:0]       cnt_q, cnt_d;
    logic [3:0]          half_q, half_d;
    logic [N_BITS-1:0]   sh_q, sh_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                half_end;

    assign half_end = (cnt_q == HALF_LAST);

    always_comb begin
        ph_d   = ph_q;
        cnt_d  = cnt_q;
        half_d = half_q;
        sh_d   = sh_q;
        cs_n_d = cs_n_q;
        sclk_d = sclk_q;
        case (ph_q)
            IDLE: begin
                if (start_i) begin
                    ph_d   = SETUP;
                    cs_n_d = 1'b0;
                    cnt_d  = '0;
                end
            end
            SETUP: begin
                if (half_end) begin
                    ph_d   = SHIFT;
                    cnt_d  = '0;
                    half_d = 4'd0;
                end else begin
                    cnt_d = cnt_q + HW'(1);
                end
            end
            SHIFT: begin
                if (half_end) begin
                    cnt_d  = '0;
                    half_d = half_q + 4'd1;
                    // Even half-periods are the low phases; their end is the rising sclk edge.
                    sclk_d = ~half_q[0];
                    if (!half_q[0]) begin
                        sh_d = {sh_q[N_BITS-2:0], sdo_i};
                    end
                    if (half_q == 4'd15) begin
                        ph_d   = IDLE;
                        cs_n_d = 1'b1;
                        sclk_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + HW'(1);
                end
            end
            default: begin
                ph_d   = IDLE;
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q   <= IDLE;
            cnt_q  <= '0;
            half_q <= 4'd0;
            sh_q   <= '0;
            cs_n_q <= 1'b1;
            sclk_q <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            cnt_q  <= cnt_d;
            half_q <= half_d;
            sh_q   <= sh_d;
            cs_n_q <= cs_n_d;
            sclk_q <= sclk_d;
        end
    end

    assign setup_done_o = (ph_q == SETUP) && half_end;
    assign done_o       = (ph_q == SHIFT) && half_end && (half_q == 4'd15);
    assign data_o       = sh_q;
    assign cs_n_o       = cs_n_q;
    assign sclk_o       = sclk_q;

endmodule

// File: rtl/temp_sensor_filter.sv
// Periodic sensor sampling with clamp and 4-sample moving average for the AC controller.
// temp_valid follows chip-select fall by SCLK_HALF*17+2 cycles; no backpressure, output just holds.
module temp_sensor_filter
    import temp_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int SCLK_HALF     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor_sdo,
    output logic       sensor_cs_n,
    output logic       sensor_sclk,
    output logic [4:0] temperature,
    output logic       temp_valid
);

    localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);

    state_t              st_q, st_d;
    logic [PW-1:0]       per_q, per_d;
    logic                first_q, first_d;
    logic                filled_q, filled_d;
    logic [1:0]          wr_ptr_q, wr_ptr_d;
    logic [3:0][4:0]     win_q, win_d;
    logic                calc_q;
    temp_t               temp_q, temp_d;
    logic                vld_q;

    logic                period_done;
    logic                spi_start;
    logic                do_update;
    logic                spi_setup_done;
    logic                spi_done;
    logic [N_BITS-1:0]   spi_data;
    temp_t               sample;
    logic [6:0]          win_sum;
    temp_t               win_avg;

    sensor_spi_rx #(
        .SCLK_HALF (SCLK_HALF)
    ) u_spi (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (spi_start),
        .sdo_i        (sensor_sdo),
        .cs_n_o       (sensor_cs_n),
        .sclk_o       (sensor_sclk),
        .setup_done_o (spi_setup_done),
        .done_o       (spi_done),
        .data_o       (spi_data)
    );

    // The first conversion after reset skips the idle wait.
    assign period_done = first_q || (per_q == PER_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE:    if (period_done)    st_d = SETUP;
            SETUP:   if (spi_setup_done) st_d = SHIFT;
            SHIFT:   if (spi_done)       st_d = UPDATE;
            UPDATE:                      st_d = IDLE;
            default:                     st_d = IDLE;
        endcase
    end

    always_comb begin
        spi_start = (st_q == IDLE) && period_done;
        do_update = (st_q == UPDATE);
    end

    assign sample = clamp_temp(spi_data);

    always_comb begin
        per_d    = per_q;
        first_d  = first_q;
        filled_d = filled_q;
        wr_ptr_d = wr_ptr_q;
        win_d    = win_q;
        if (st_q == IDLE) begin
            per_d = period_done ? '0 : per_q + PW'(1);
        end
        if (spi_start) begin
            first_d = 1'b0;
        end
        if (do_update) begin
            per_d = '0;
            if (!filled_q) begin
                win_d    = {4{sample}};
                wr_ptr_d = 2'd1;
                filled_d = 1'b1;
            end else begin
                win_d[wr_ptr_q] = sample;
                wr_ptr_d        = wr_ptr_q + 2'd1;
            end
        end
    end

    assign win_sum = 7'(win_q[0]) + 7'(win_q[1]) + 7'(win_q[2]) + 7'(win_q[3]);
    assign win_avg = 5'(win_sum >> 2);
    assign temp_d  = calc_q ? win_avg : temp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_q    <= '0;
            first_q  <= 1'b1;
            filled_q <= 1'b0;
            wr_ptr_q <= 2'd0;
            win_q    <= '0;
            calc_q   <= 1'b0;
            temp_q   <= T_RESET;
            vld_q    <= 1'b0;
        end else begin
            per_q    <= per_d;
            first_q  <= first_d;
            filled_q <= filled_d;
            wr_ptr_q <= wr_ptr_d;
            win_q    <= win_d;
            calc_q   <= do_update;
            temp_q   <= temp_d;
            vld_q    <= calc_q;
        end
    end

    assign temperature = temp_q;
    assign temp_valid  = vld_q;

endmodule
